// File: rtl/alu_share_pkg.sv
// ----------------------------------------------------------------------------
// alu_share_pkg : op and FSM state encodings for the shared ALU arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_share_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core : operand registers plus a pipelined add/sub/and/or datapath
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_core
  import alu_share_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W:0]   o_result
);

  op_t               r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W:0]   w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= OP_ADD;
      r_a  <= '0;
      r_b  <= '0;
    end else if (i_load) begin
      r_op <= op_t'(i_op);
      r_a  <= i_a;
      r_b  <= i_b;
    end
  end

  always_comb begin
    w_res = '0;
    case (r_op)
      OP_ADD:  w_res = {1'b0, r_a} + {1'b0, r_b};
      OP_SUB:  w_res = {1'b0, r_a} - {1'b0, r_b};
      OP_AND:  w_res = {1'b0, r_a & r_b};
      OP_OR:   w_res = {1'b0, r_a | r_b};
      default: w_res = '0;
    endcase
  end

  // The operand register is the first stage; the owner registers the last.
  generate
    if (ALU_LATENCY == 1) begin : g_direct
      assign o_result = w_res;
    end else begin : g_pipe
      logic [DATA_W:0] r_stage [ALU_LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < ALU_LATENCY-1; k++) r_stage[k] <= '0;
        end else begin
          r_stage[0] <= w_res;
          for (int k = 1; k < ALU_LATENCY-1; k++) r_stage[k] <= r_stage[k-1];
        end
      end

      assign o_result = r_stage[ALU_LATENCY-2];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter : round-robin sharing of one ALU among NUM_REQ requesters
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int ALU_LATENCY = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [2*NUM_REQ-1:0]      i_req_op,
  input  logic [DATA_W*NUM_REQ-1:0] i_req_a,
  input  logic [DATA_W*NUM_REQ-1:0] i_req_b,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [DATA_W:0]           o_rsp_data,
  output logic                      o_busy,
  output logic [15:0]               o_ops_done
);

  localparam int LAT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [ID_W-1:0]   r_rsp_id;
  logic [DATA_W:0]   r_rsp_data;
  logic [15:0]       r_ops_done;

  logic [1:0]        w_op_arr [NUM_REQ];
  logic [DATA_W-1:0] w_a_arr  [NUM_REQ];
  logic [DATA_W-1:0] w_b_arr  [NUM_REQ];

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_idx;
  logic               w_found;
  logic               w_accept;
  logic [ID_W-1:0]    w_rr_next;
  logic [DATA_W:0]    w_core_result;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_op_arr[g] = i_req_op[2*g +: 2];
      assign w_a_arr[g]  = i_req_a[DATA_W*g +: DATA_W];
      assign w_b_arr[g]  = i_req_b[DATA_W*g +: DATA_W];
    end
  endgenerate

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && i_req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant_idx    = w_idx;
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  // Gated by rst_n so no grant is visible while reset is held.
  assign o_req_ready = (r_state == ST_IDLE && rst_n) ? w_grant : '0;
  assign w_accept    = (r_state == ST_IDLE) && w_found;
  assign w_rr_next   = (w_grant_idx == ID_W'(NUM_REQ-1)) ? '0 : w_grant_idx + ID_W'(1);

  alu_core #(
    .DATA_W      (DATA_W),
    .ALU_LATENCY (ALU_LATENCY)
  ) u_alu_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_op     (w_op_arr[w_grant_idx]),
    .i_a      (w_a_arr[w_grant_idx]),
    .i_b      (w_b_arr[w_grant_idx]),
    .o_result (w_core_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_lat_cnt  <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_ops_done <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_EXEC;
            r_lat_cnt <= LAT_W'(ALU_LATENCY-1);
            r_rr_ptr  <= w_rr_next;
            r_rsp_id  <= w_grant_idx;
          end
        end
        ST_EXEC: begin
          if (r_lat_cnt == '0) begin
            r_rsp_data <= w_core_result;
            r_state    <= ST_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state <= ST_IDLE;
            if (r_ops_done != 16'hFFFF) r_ops_done <= r_ops_done + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_ops_done  = r_ops_done;

endmodule

`default_nettype wire
